// File: rtl/fu_queue_wrap.sv
// Functional-unit queue wrapper: collapsing age-ordered issue queue with
// operand wakeup, single-cycle integer execute and registered writeback.
module fu_queue_wrap #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int QUEUE_SIZE   = 4,
  parameter int FU_COUNT     = 4,
  parameter int FU_INDEX     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_valid,
  output logic                    queue_ready,
  input  logic [INST_ID_BITS-1:0] inst_id,
  input  logic [31:0]             raw_instr,
  input  logic [63:0]             instr_pc,
  input  logic                    prn_input_valid  [MAX_OPERANDS],
  input  logic                    prn_input_ready  [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     prn_input        [MAX_OPERANDS],
  input  logic                    prn_output_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     prn_output       [MAX_OPERANDS],
  input  logic                    set_prn_ready    [FU_COUNT-1][MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     set_prn          [FU_COUNT-1][MAX_OPERANDS],
  input  logic [63:0]             prf_op           [MAX_OPERANDS],
  output logic                    prf_read_enable  [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prf_read_prn     [MAX_OPERANDS],
  output logic [63:0]             prf_write        [MAX_OPERANDS],
  output logic                    prf_write_enable [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prf_write_prn    [MAX_OPERANDS],
  output logic [INST_ID_BITS-1:0] fu_out_inst_id,
  output logic                    fu_out_valid
);

  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam int IW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]               id;
    logic [31:0]                           instr;
    logic [63:0]                           pc;
    logic [MAX_OPERANDS-1:0]               src_valid;
    logic [MAX_OPERANDS-1:0]               src_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src_prn;
    logic                                  dst_valid;
    logic [PRN_BITS-1:0]                   dst_prn;
  } entry_t;

  entry_t                  q_r [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]   vld_r;

  logic [CW-1:0]           count_s;
  logic [CW-1:0]           enq_pos_s;
  logic [QUEUE_SIZE-1:0]   elig_s;
  logic                    issue_s;
  logic [IW-1:0]           issue_idx_s;
  entry_t                  iss_s;
  entry_t                  new_s;
  entry_t                  ext_s [QUEUE_SIZE+1];
  logic [QUEUE_SIZE:0]     ext_v_s;
  entry_t                  nq_s [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]   nv_s;
  logic [2**PRN_BITS-1:0]  wake_s;
  logic [63:0]             opa_s;
  logic [63:0]             opb_s;
  logic [63:0]             result_s;
  logic                    unused_s;

  // Occupancy, per-entry eligibility and oldest-eligible selection
  always_comb begin
    count_s     = '0;
    elig_s      = '0;
    issue_s     = 1'b0;
    issue_idx_s = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      count_s   = count_s + CW'(vld_r[i]);
      elig_s[i] = vld_r[i] && ((q_r[i].src_valid & ~q_r[i].src_ready) == '0);
    end
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      if (elig_s[i] && !issue_s) begin
        issue_s     = 1'b1;
        issue_idx_s = IW'(i);
      end else begin
        issue_idx_s = issue_idx_s;
      end
    end
    queue_ready = (count_s < CW'(QUEUE_SIZE));
    iss_s       = q_r[issue_idx_s];
  end

  // Register file read strobes for the issuing entry
  always_comb begin
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      prf_read_enable[j] = issue_s & iss_s.src_valid[j];
      if (prf_read_enable[j]) begin
        prf_read_prn[j] = iss_s.src_prn[j];
      end else begin
        prf_read_prn[j] = '0;
      end
    end
  end

  // Integer execute on the issuing entry
  always_comb begin
    opa_s    = iss_s.src_valid[0] ? prf_op[0] : 64'd0;
    opb_s    = iss_s.src_valid[1] ? prf_op[1] : 64'd0;
    result_s = 64'd0;
    case (iss_s.instr[31:28])
      4'd0:    result_s = opa_s + opb_s;
      4'd1:    result_s = opa_s - opb_s;
      4'd2:    result_s = opa_s & opb_s;
      4'd3:    result_s = opa_s | opb_s;
      4'd4:    result_s = opa_s ^ opb_s;
      4'd5:    result_s = opa_s + {52'd0, iss_s.instr[21:10]};
      4'd6:    result_s = opa_s << opb_s[5:0];
      4'd7:    result_s = opa_s >> opb_s[5:0];
      4'd8:    result_s = iss_s.pc + {{43{iss_s.instr[20]}}, iss_s.instr[20:0]};
      default: result_s = 64'd0;
    endcase
    unused_s = ^{iss_s.instr[27:22], iss_s.src_ready, 1'(FU_INDEX)};
    for (int j = 2; j < MAX_OPERANDS; j++) begin
      unused_s = unused_s ^ (^prf_op[j]);
    end
    for (int j = 1; j < MAX_OPERANDS; j++) begin
      unused_s = unused_s ^ prn_output_valid[j] ^ (^prn_output[j]);
    end
  end

  // Wakeup vector, collapse-on-issue and enqueue placement
  always_comb begin
    wake_s = '0;
    for (int k = 0; k < FU_COUNT - 1; k++) begin
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        wake_s[set_prn[k][j]] = wake_s[set_prn[k][j]] | set_prn_ready[k][j];
      end
    end
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      wake_s[prf_write_prn[j]] = wake_s[prf_write_prn[j]] | prf_write_enable[j];
    end

    new_s           = '0;
    new_s.id        = inst_id;
    new_s.instr     = raw_instr;
    new_s.pc        = instr_pc;
    new_s.dst_valid = prn_output_valid[0];
    new_s.dst_prn   = prn_output[0];
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      new_s.src_valid[j] = prn_input_valid[j];
      new_s.src_ready[j] = prn_input_ready[j];
      new_s.src_prn[j]   = prn_input[j];
    end

    for (int i = 0; i < QUEUE_SIZE; i++) begin
      ext_s[i]   = q_r[i];
      ext_v_s[i] = vld_r[i];
    end
    ext_s[QUEUE_SIZE]   = '0;
    ext_v_s[QUEUE_SIZE] = 1'b0;

    // the new entry lands behind the youngest survivor of this cycle's issue
    enq_pos_s = count_s - CW'(issue_s);
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      if (issue_s && (IW'(i) >= issue_idx_s)) begin
        nq_s[i] = ext_s[i+1];
        nv_s[i] = ext_v_s[i+1];
      end else begin
        nq_s[i] = ext_s[i];
        nv_s[i] = ext_v_s[i];
      end
      if (inst_valid && queue_ready && (enq_pos_s == CW'(i))) begin
        nq_s[i] = new_s;
        nv_s[i] = 1'b1;
      end else begin
        nv_s[i] = nv_s[i];
      end
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        nq_s[i].src_ready[j] = nq_s[i].src_ready[j] |
                               (nq_s[i].src_valid[j] & wake_s[nq_s[i].src_prn[j]]);
      end
    end
  end

  // Queue state and registered writeback/completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r          <= '0;
      fu_out_valid   <= 1'b0;
      fu_out_inst_id <= '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        q_r[i] <= '0;
      end
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        prf_write[j]        <= 64'd0;
        prf_write_enable[j] <= 1'b0;
        prf_write_prn[j]    <= '0;
      end
    end else begin
      vld_r <= nv_s;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        q_r[i] <= nq_s[i];
      end
      for (int j = 1; j < MAX_OPERANDS; j++) begin
        prf_write[j]        <= 64'd0;
        prf_write_enable[j] <= 1'b0;
        prf_write_prn[j]    <= '0;
      end
      if (issue_s) begin
        prf_write[0]        <= result_s;
        prf_write_enable[0] <= iss_s.dst_valid;
        prf_write_prn[0]    <= iss_s.dst_prn;
        fu_out_valid        <= 1'b1;
        fu_out_inst_id      <= iss_s.id;
      end else begin
        prf_write[0]        <= 64'd0;
        prf_write_enable[0] <= 1'b0;
        prf_write_prn[0]    <= '0;
        fu_out_valid        <= 1'b0;
        fu_out_inst_id      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fu_queue_wrap.sv
// Randomized and directed bench for fu_queue_wrap against a queue-based
// behavioural model of the issue queue, wakeup and ALU rules.
module tb_fu_queue_wrap;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid;
  logic        queue_ready;
  logic [5:0]  inst_id;
  logic [31:0] raw_instr;
  logic [63:0] instr_pc;
  logic        prn_input_valid  [3];
  logic        prn_input_ready  [3];
  logic [5:0]  prn_input        [3];
  logic        prn_output_valid [3];
  logic [5:0]  prn_output       [3];
  logic        set_prn_ready    [3][3];
  logic [5:0]  set_prn          [3][3];
  logic [63:0] prf_op           [3];
  logic        prf_read_enable  [3];
  logic [5:0]  prf_read_prn     [3];
  logic [63:0] prf_write        [3];
  logic        prf_write_enable [3];
  logic [5:0]  prf_write_prn    [3];
  logic [5:0]  fu_out_inst_id;
  logic        fu_out_valid;

  fu_queue_wrap dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .queue_ready(queue_ready),
    .inst_id(inst_id), .raw_instr(raw_instr), .instr_pc(instr_pc),
    .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready),
    .prn_input(prn_input), .prn_output_valid(prn_output_valid),
    .prn_output(prn_output), .set_prn_ready(set_prn_ready), .set_prn(set_prn),
    .prf_op(prf_op), .prf_read_enable(prf_read_enable),
    .prf_read_prn(prf_read_prn), .prf_write(prf_write),
    .prf_write_enable(prf_write_enable), .prf_write_prn(prf_write_prn),
    .fu_out_inst_id(fu_out_inst_id), .fu_out_valid(fu_out_valid)
  );

  always #5 clk = ~clk;

  logic [63:0] rf [64];
  always_comb begin
    for (int j = 0; j < 3; j++) prf_op[j] = rf[prf_read_prn[j]];
  end

  typedef struct {
    logic [5:0]  id;
    logic [31:0] ins;
    logic [63:0] pc;
    logic [2:0]  sv;
    logic [2:0]  sr;
    logic [5:0]  sp [3];
    logic        dv;
    logic [5:0]  dp;
  } ment_t;

  ment_t       mq [$];
  logic        e_fv, e_we;
  logic [5:0]  e_id, e_wp;
  logic [63:0] e_wd;
  int          checks = 0;
  int          errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [31:0] ins, input logic [63:0] pc,
                                          input logic [63:0] a, input logic [63:0] b);
    case (ins[31:28])
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a + {52'd0, ins[21:10]};
      4'd6:    return a << b[5:0];
      4'd7:    return a >> b[5:0];
      4'd8:    return pc + {{43{ins[20]}}, ins[20:0]};
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    e_fv = 1'b0; e_we = 1'b0; e_id = 6'd0; e_wp = 6'd0; e_wd = 64'd0;
  endtask

  // One clock: check combinational outputs, advance the model, check writeback.
  task automatic step();
    int          iss;
    bit          acc;
    ment_t       e;
    ment_t       ne;
    logic [63:0] a, b, wake;
    logic        n_fv, n_we;
    logic [5:0]  n_id, n_wp;
    logic [63:0] n_wd;
    #1;
    check_val("queue_ready", 64'(queue_ready), 64'(mq.size() < 4));
    iss = -1;
    foreach (mq[i]) if (iss < 0 && ((mq[i].sv & ~mq[i].sr) == 3'b000)) iss = i;
    for (int j = 0; j < 3; j++) begin
      if (iss >= 0 && mq[iss].sv[j]) begin
        check_val("rd_en", 64'(prf_read_enable[j]), 64'd1);
        check_val("rd_prn", 64'(prf_read_prn[j]), 64'(mq[iss].sp[j]));
      end else begin
        check_val("rd_en", 64'(prf_read_enable[j]), 64'd0);
        check_val("rd_prn", 64'(prf_read_prn[j]), 64'd0);
      end
    end
    wake = 64'd0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        if (set_prn_ready[k][j]) wake[set_prn[k][j]] = 1'b1;
    if (e_we) wake[e_wp] = 1'b1;
    acc = inst_valid && (mq.size() < 4);
    if (iss >= 0) begin
      e = mq[iss];
      a = e.sv[0] ? rf[e.sp[0]] : 64'd0;
      b = e.sv[1] ? rf[e.sp[1]] : 64'd0;
      n_fv = 1'b1; n_id = e.id; n_we = e.dv; n_wp = e.dp;
      n_wd = ref_alu(e.ins, e.pc, a, b);
      mq.delete(iss);
    end else begin
      n_fv = 1'b0; n_id = 6'd0; n_we = 1'b0; n_wp = 6'd0; n_wd = 64'd0;
    end
    foreach (mq[i])
      for (int j = 0; j < 3; j++)
        if (mq[i].sv[j] && wake[mq[i].sp[j]]) mq[i].sr[j] = 1'b1;
    if (acc) begin
      ne.id = inst_id; ne.ins = raw_instr; ne.pc = instr_pc;
      ne.dv = prn_output_valid[0]; ne.dp = prn_output[0];
      for (int j = 0; j < 3; j++) begin
        ne.sv[j] = prn_input_valid[j];
        ne.sp[j] = prn_input[j];
        ne.sr[j] = prn_input_ready[j] | wake[prn_input[j]];
      end
      mq.push_back(ne);
    end
    @(posedge clk);
    #1;
    e_fv = n_fv; e_id = n_id; e_we = n_we; e_wp = n_wp; e_wd = n_wd;
    check_val("fu_out_valid", 64'(fu_out_valid), 64'(e_fv));
    check_val("fu_out_inst_id", 64'(fu_out_inst_id), 64'(e_id));
    check_val("wr_en0", 64'(prf_write_enable[0]), 64'(e_we));
    check_val("wr_prn0", 64'(prf_write_prn[0]), 64'(e_wp));
    check_val("wr_data0", prf_write[0], e_wd);
    for (int j = 1; j < 3; j++) begin
      check_val("wr_en_hi", 64'(prf_write_enable[j]), 64'd0);
      check_val("wr_prn_hi", 64'(prf_write_prn[j]), 64'd0);
      check_val("wr_data_hi", prf_write[j], 64'd0);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    inst_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      prn_input_valid[j] = 1'b0; prn_input_ready[j] = 1'b0; prn_input[j] = 6'd0;
      prn_output_valid[j] = 1'b0; prn_output[j] = 6'd0;
      for (int k = 0; k < 3; k++) begin
        set_prn_ready[k][j] = 1'b0; set_prn[k][j] = 6'd0;
      end
    end
  endtask

  task automatic put(input logic [5:0] id, input logic [31:0] ins, input logic [63:0] pc,
                     input logic [2:0] sv, input logic [2:0] sr,
                     input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2,
                     input logic dv, input logic [5:0] dp);
    idle();
    inst_valid = 1'b1; inst_id = id; raw_instr = ins; instr_pc = pc;
    for (int j = 0; j < 3; j++) begin
      prn_input_valid[j] = sv[j]; prn_input_ready[j] = sr[j];
    end
    prn_input[0] = p0; prn_input[1] = p1; prn_input[2] = p2;
    prn_output_valid[0] = dv; prn_output[0] = dp;
  endtask

  initial begin
    logic [63:0] exp_sub;
    idle();
    inst_id = 6'd0; raw_instr = 32'd0; instr_pc = 64'd0;
    for (int i = 0; i < 64; i++) rf[i] = {$urandom, $urandom};
    rf[3] = 64'd10; rf[4] = 64'd20; rf[40] = 64'hFFFF_FFFF_FFFF_FFFF;
    model_clear();
    #1 rst = 1'b1;
    #2;
    check_val("rst_queue_ready", 64'(queue_ready), 64'd1);
    check_val("rst_fu_out_valid", 64'(fu_out_valid), 64'd0);
    check_val("rst_wr_en0", 64'(prf_write_enable[0]), 64'd0);
    check_val("rst_rd_en0", 64'(prf_read_enable[0]), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ADD id 5: p3 + p4 -> p7
    put(6'd5, 32'h0000_0000, 64'd0, 3'b011, 3'b011, 6'd3, 6'd4, 6'd0, 1'b1, 6'd7);
    step(); idle(); step();
    check_val("add_result", prf_write[0], 64'd30);
    check_val("add_prn", 64'(prf_write_prn[0]), 64'd7);
    check_val("add_id", 64'(fu_out_inst_id), 64'd5);

    // SUB waits for a late broadcast of p9
    put(6'd6, 32'h1000_0000, 64'd0, 3'b011, 3'b001, 6'd3, 6'd9, 6'd0, 1'b1, 6'd8);
    step(); idle(); step(); step();
    set_prn_ready[1][0] = 1'b1; set_prn[1][0] = 6'd9;
    step();
    check_val("sub_no_early_issue", 64'(fu_out_valid), 64'd0);
    idle(); step();
    exp_sub = rf[3] - rf[9];
    check_val("sub_id", 64'(fu_out_inst_id), 64'd6);
    check_val("sub_result", prf_write[0], exp_sub);

    // Fill with four unready entries; fifth is dropped
    for (int i = 0; i < 4; i++) begin
      put(6'(10 + i), 32'h0000_0000, 64'd0, 3'b001, 3'b000, 6'(20 + i), 6'd0, 6'd0, 1'b1, 6'd33);
      step();
    end
    put(6'd14, 32'h0000_0000, 64'd0, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 6'd34);
    #1 check_val("full_queue_ready", 64'(queue_ready), 64'd0);
    step();
    idle();
    set_prn_ready[0][0] = 1'b1; set_prn[0][0] = 6'd20;
    set_prn_ready[0][1] = 1'b1; set_prn[0][1] = 6'd21;
    set_prn_ready[0][2] = 1'b1; set_prn[0][2] = 6'd22;
    set_prn_ready[1][0] = 1'b1; set_prn[1][0] = 6'd23;
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("fifo_valid", 64'(fu_out_valid), 64'd1);
      check_val("fifo_id", 64'(fu_out_inst_id), 64'(10 + i));
    end
    step();
    check_val("dropped_not_completed", 64'(fu_out_valid), 64'd0);

    // Two ready entries complete oldest first
    put(6'd1, 32'h2000_0000, 64'd0, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 6'd30);
    step();
    put(6'd2, 32'h3000_0000, 64'd0, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 6'd31);
    step();
    check_val("order_first", 64'(fu_out_inst_id), 64'd1);
    idle(); step();
    check_val("order_second", 64'(fu_out_inst_id), 64'd2);

    // ADDI wraps to zero; ADR with negative immediate
    put(6'd20, {4'd5, 6'd0, 12'd1, 10'd0}, 64'd0, 3'b001, 3'b001, 6'd40, 6'd0, 6'd0, 1'b1, 6'd41);
    step(); idle(); step();
    check_val("addi_wrap", prf_write[0], 64'd0);
    put(6'd21, {4'd8, 7'd0, 21'h1F_FFFC}, 64'h1000, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 6'd42);
    step(); idle(); step();
    check_val("adr_neg", prf_write[0], 64'h0000_0000_0000_0FFC);

    // Reset with two entries queued
    put(6'd30, 32'h0000_0000, 64'd0, 3'b001, 3'b000, 6'd50, 6'd0, 6'd0, 1'b1, 6'd43);
    step();
    put(6'd31, 32'h0000_0000, 64'd0, 3'b001, 3'b000, 6'd51, 6'd0, 6'd0, 1'b1, 6'd44);
    step(); idle();
    rst = 1'b1;
    #1;
    check_val("midrst_queue_ready", 64'(queue_ready), 64'd1);
    check_val("midrst_fu_out_valid", 64'(fu_out_valid), 64'd0);
    model_clear();
    @(posedge clk); #1;
    check_val("midrst_no_completion", 64'(fu_out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_prn_ready[0][0] = 1'b1; set_prn[0][0] = 6'd50;
    set_prn_ready[0][1] = 1'b1; set_prn[0][1] = 6'd51;
    step(); idle(); step(); step();
    check_val("midrst_flushed", 64'(fu_out_valid), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      inst_valid = 1'($urandom_range(0, 1));
      inst_id    = 6'($urandom);
      raw_instr  = {4'($urandom_range(0, 9)), 28'($urandom)};
      instr_pc   = {$urandom, $urandom};
      for (int j = 0; j < 3; j++) begin
        prn_input_valid[j]  = 1'($urandom_range(0, 1));
        prn_input_ready[j]  = 1'($urandom_range(0, 1));
        prn_input[j]        = 6'($urandom_range(0, 15));
        prn_output_valid[j] = 1'($urandom_range(0, 1));
        prn_output[j]       = 6'($urandom_range(0, 15));
        for (int k = 0; k < 3; k++) begin
          set_prn_ready[k][j] = ($urandom_range(0, 3) == 0);
          set_prn[k][j]       = 6'($urandom_range(0, 15));
        end
      end
      step();
    end
    for (int c = 0; c < 40; c++) begin
      idle();
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 3; k++) begin
          set_prn_ready[k][j] = ($urandom_range(0, 1) == 0);
          set_prn[k][j]       = 6'($urandom_range(0, 15));
        end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_queue_wrap.md
Name: fu_queue_wrap

Overview:
- Generic functional-unit/queue wrapper: buffers up to QUEUE_SIZE renamed instructions and wakes their source operands from other units' PRN-ready broadcasts.
- Issues the oldest ready instruction, reads the register file, executes a simple integer op, then writes the result back and reports completion.
- Instantiated once per non-memory FU slot (index FU_INDEX) under the instruction router.

Parameters:
INST_ID_BITS, 6, width of instruction id
PRN_BITS, 6, physical register number width
MAX_OPERANDS, 3, source/destination operand slots per instruction
QUEUE_SIZE, 4, queue entries
FU_COUNT, 4, total FUs; FU_COUNT-1 external broadcast sources
FU_INDEX, 0, this unit's index (informational, no behavioural effect)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset is asynchronous and active-high
inst_valid  in  1  enqueue request this cycle
queue_ready  out  1  queue has a free entry
inst_id  in  INST_ID_BITS  instruction id
raw_instr  in  32  instruction word
instr_pc  in  64  instruction PC
prn_input_valid  in  [MAX_OPERANDS]x1  source slot used
prn_input_ready  in  [MAX_OPERANDS]x1  source already ready at dispatch
prn_input  in  [MAX_OPERANDS]xPRN_BITS  source PRNs
prn_output_valid  in  [MAX_OPERANDS]x1  destination slot used
prn_output  in  [MAX_OPERANDS]xPRN_BITS  destination PRNs
set_prn_ready  in  [FU_COUNT-1][MAX_OPERANDS]x1  wakeup strobes from other FUs
set_prn  in  [FU_COUNT-1][MAX_OPERANDS]xPRN_BITS  wakeup PRNs
prf_op  in  [MAX_OPERANDS]x64  register file read data (combinational)
prf_read_enable  out  [MAX_OPERANDS]x1  read strobe
prf_read_prn  out  [MAX_OPERANDS]xPRN_BITS  read address
prf_write  out  [MAX_OPERANDS]x64  write data
prf_write_enable  out  [MAX_OPERANDS]x1  write strobe
prf_write_prn  out  [MAX_OPERANDS]xPRN_BITS  write address
fu_out_inst_id  out  INST_ID_BITS  completed instruction id
fu_out_valid  out  1  completion strobe

Behaviour:
- Reset (async): all entries invalid; prf_write*, prf_write_prn, fu_out_valid and fu_out_inst_id are 0. Combinational outputs follow from the empty queue: queue_ready=1, prf_read_enable=0, prf_read_prn=0.
- Queue structure:
  - Collapsing, age-ordered; entry 0 is the oldest.
  - Entry holds: id, instr, pc, per-slot src valid/ready/prn, dst valid/prn.
- queue_ready = (occupancy < QUEUE_SIZE), computed from registered state only; a same-cycle issue does not free space.
- Enqueue:
  - inst_valid && queue_ready writes a new entry behind the youngest valid entry at the clock edge.
  - inst_valid while full is ignored; the instruction is lost and upstream must obey queue_ready.
- Wakeup:
  - Each cycle, any valid, not-ready source whose prn equals set_prn[k][j] with set_prn_ready[k][j]=1 becomes ready at the edge.
  - The unit's own prf_write_enable/prf_write_prn also wake sources.
  - The same matching applies to an instruction being enqueued, so a broadcast in its enqueue cycle is not missed.
- Issue:
  - An entry is eligible when every source with valid=1 is ready; unused slots count as ready.
  - Each cycle the oldest eligible entry issues. An entry cannot issue in its enqueue cycle.
  - On issue: prf_read_enable[j] = src valid[j], prf_read_prn[j] = src prn[j] (0 when not enabled); prf_op is sampled that same cycle.
  - The issued entry is removed at the edge and younger entries shift down. A simultaneous enqueue lands in the correct post-shift slot.
- Execute: operand j = prf_op[j] if src valid[j], else 0. op = raw_instr[31:28], all 64-bit with wrap-around:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 ORR
  - 4 EOR
  - 5 ADDI a+zext(raw_instr[21:10])
  - 6 LSL a<<b[5:0]
  - 7 LSR a>>b[5:0]
  - 8 ADR instr_pc+sext(raw_instr[20:0])
  - other: 0
- Writeback, registered, exactly one cycle after issue, for one cycle:
  - Slot 0: prf_write_enable[0] = dst valid[0], prf_write_prn[0] = dst prn[0], prf_write[0] = result.
  - Slots j>0: enable 0, data 0, prn 0.
  - fu_out_valid=1 and fu_out_inst_id = id.
  - These outputs return to 0 in the next cycle unless another instruction issued.
- Throughput: one issue and one completion per cycle.

Test Plan:
- Reset -> queue_ready=1, fu_out_valid=0, all prf_write_enable=0; assert rst mid-operation with 2 queued -> queue empties immediately, no completion.
- Enqueue ADD id=5, src0 p3=10, src1 p4=20, both ready, dst p7 -> reads p3/p4 next cycle; the cycle after: prf_write[0]=30, prn 7, fu_out_inst_id=5.
- Enqueue SUB with src1 p9 not ready; broadcast set_prn[1][0]=9 three cycles later -> no issue before the broadcast; issue the cycle after it.
- Four unready enqueues -> queue_ready=0; a fifth inst_valid is dropped; wake all four -> completion in FIFO order, one per cycle.
- Two ready entries (ids 1, 2) -> id 1 completes first, then id 2 on the next cycle.
- ADDI 0xFFFF_FFFF_FFFF_FFFF + imm 1 -> result 0 (wrap); ADR pc 0x1000, imm -4 -> 0xFFC.
